// File: rtl/g729_acorr_pkg.sv
// Shared constants and FSM encoding for the autocorrelation stage.
package g729_acorr_pkg;

  localparam int L_WINDOW = 240;
  localparam int M        = 10;
  localparam int XADDR_W  = 8;
  localparam int RADDR_W  = 4;

  localparam logic [31:0] MAX_32 = 32'h7FFF_FFFF;
  localparam logic [31:0] MIN_32 = 32'h8000_0000;

  localparam logic [3:0] SHIFT_STEP = 4'd2;
  localparam logic [3:0] SHIFT_MAX  = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_FIN
  } acorr_state_t;

endpackage

// File: rtl/autocorr_mac_if.sv
// Control, sample-memory and result-memory signals of the autocorrelation engine.
// shiftOut exists only when ACORR_OVF_RETRY_EN is defined.
interface autocorr_mac_if;
  import g729_acorr_pkg::*;

  logic               start;
  logic [XADDR_W-1:0] xAddrA;
  logic [XADDR_W-1:0] xAddrB;
  logic [15:0]        xInA;
  logic [15:0]        xInB;
  logic [31:0]        outData;
  logic [RADDR_W-1:0] outAddr;
  logic               outWrite;
  logic               busy;
  logic               done;
  logic               ovf;
`ifdef ACORR_OVF_RETRY_EN
  logic [3:0]         shiftOut;

  modport slave (
    input  start, xInA, xInB,
    output xAddrA, xAddrB, outData, outAddr, outWrite, busy, done, ovf, shiftOut
  );
  modport master (
    output start, xInA, xInB,
    input  xAddrA, xAddrB, outData, outAddr, outWrite, busy, done, ovf, shiftOut
  );
`else
  modport slave (
    input  start, xInA, xInB,
    output xAddrA, xAddrB, outData, outAddr, outWrite, busy, done, ovf
  );
  modport master (
    output start, xInA, xInB,
    input  xAddrA, xAddrB, outData, outAddr, outWrite, busy, done, ovf
  );
`endif
endinterface

// File: rtl/autocorr_mac_l_mac_sat.sv
// L_mac building block: registered saturating 2*a*b product and a saturating
// 32-bit add of that product onto an external accumulator.
module l_mac_sat
  import g729_acorr_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        mul_en_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [31:0] acc_i,
  output logic        prod_sat_o,
  output logic [31:0] sum_o,
  output logic        sum_sat_o
);

  logic signed [31:0] raw;
  logic [31:0]        prod_q, prod_d;
  logic               prod_sat_q, prod_sat_d;
  logic [32:0]        wide;

  assign raw = 32'($signed(a_i)) * 32'($signed(b_i));

  // Only -1.0 * -1.0 overflows when doubled.
  always_comb begin
    prod_d     = {raw[30:0], 1'b0};
    prod_sat_d = 1'b0;
    if (raw == 32'sh4000_0000) begin
      prod_d     = MAX_32;
      prod_sat_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prod_q     <= '0;
      prod_sat_q <= 1'b0;
    end else if (mul_en_i) begin
      prod_q     <= prod_d;
      prod_sat_q <= prod_sat_d;
    end
  end

  assign wide       = {acc_i[31], acc_i} + {prod_q[31], prod_q};
  assign sum_sat_o  = wide[32] ^ wide[31];
  assign sum_o      = sum_sat_o ? (wide[32] ? MIN_32 : MAX_32) : wide[31:0];
  assign prod_sat_o = prod_sat_q;

endmodule

// File: rtl/autocorr_mac.sv
// Autocorrelation engine: computes r[0..M] over the windowed buffer with L_mac arithmetic.
// Defining ACORR_OVF_RETRY_EN rescales the samples and reruns when r[0] saturates.
module autocorr_mac
  import g729_acorr_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  autocorr_mac_if.slave bus
);

  acorr_state_t       state_q, state_d;
  logic [XADDR_W-1:0] i_q, i_d;
  logic [RADDR_W-1:0] k_q, k_d;
  logic [1:0]         drain_q, drain_d;
  logic [31:0]        acc_q, acc_d;
  logic [31:0]        out_data_q, out_data_d;
  logic               ovf_q, ovf_d;
  logic               data_vld_q, prod_vld_q;
  logic [15:0]        op_a, op_b;
  logic [31:0]        sum;
  logic               prod_sat, sum_sat;

`ifdef ACORR_OVF_RETRY_EN
  logic [3:0] shift_q, shift_d;
  assign op_a         = $signed(bus.xInA) >>> shift_q;
  assign op_b         = $signed(bus.xInB) >>> shift_q;
  assign bus.shiftOut = shift_q;
`else
  assign op_a = bus.xInA;
  assign op_b = bus.xInB;
`endif

  l_mac_sat u_mac (
    .clock      (clock),
    .reset      (reset),
    .mul_en_i   (data_vld_q),
    .a_i        (op_a),
    .b_i        (op_b),
    .acc_i      (acc_q),
    .prod_sat_o (prod_sat),
    .sum_o      (sum),
    .sum_sat_o  (sum_sat)
  );

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    k_d        = k_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    drain_d    = drain_q;
    out_data_d = out_data_q;
`ifdef ACORR_OVF_RETRY_EN
    shift_d    = shift_q;
`endif
    if (prod_vld_q) begin
      acc_d = sum;
      if (prod_sat || sum_sat) ovf_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_INIT;
          ovf_d   = 1'b0;
`ifdef ACORR_OVF_RETRY_EN
          shift_d = '0;
`endif
        end
      end
      ST_INIT: begin
        k_d     = '0;
        i_d     = '0;
        acc_d   = 32'd1;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_q == XADDR_W'(L_WINDOW - 1)) begin
          drain_d = '0;
          state_d = ST_DRAIN;
        end else begin
          i_d = i_q + XADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd2) begin
          state_d = ST_WRITE;
`ifdef ACORR_OVF_RETRY_EN
          // A saturated r[0] discards the pass and restarts with smaller operands.
          if (k_q == '0 && ovf_q && shift_q < SHIFT_MAX) begin
            shift_d = shift_q + SHIFT_STEP;
            ovf_d   = 1'b0;
            state_d = ST_INIT;
          end
`endif
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      ST_WRITE: begin
        out_data_d = acc_q;
        if (k_q < RADDR_W'(M)) begin
          k_d     = k_q + RADDR_W'(1);
          i_d     = XADDR_W'(k_q) + XADDR_W'(1);
          acc_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      i_q        <= '0;
      k_q        <= '0;
      drain_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
      data_vld_q <= 1'b0;
      prod_vld_q <= 1'b0;
`ifdef ACORR_OVF_RETRY_EN
      shift_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
      data_vld_q <= (state_q == ST_RUN);
      prod_vld_q <= data_vld_q;
`ifdef ACORR_OVF_RETRY_EN
      shift_q    <= shift_d;
`endif
    end
  end

  assign bus.xAddrA   = i_q;
  assign bus.xAddrB   = i_q - XADDR_W'(k_q);
  assign bus.outAddr  = k_q;
  assign bus.outWrite = (state_q == ST_WRITE);
  assign bus.outData  = (state_q == ST_WRITE) ? acc_q : out_data_q;
  assign bus.busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
  assign bus.done     = (state_q == ST_FIN);
  assign bus.ovf      = ovf_q;

endmodule
